// File: rtl/serial_param_tx_if.sv
// rtl/serial_param_tx_if.sv - word handshake between loader client and serial transmitter
interface serial_param_tx_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/serial_param_tx.sv
// rtl/serial_param_tx.sv - serial LSB-first parameter word transmitter with settle delay
module serial_param_tx #(
  parameter int WIDTH    = 12,
  parameter int PIPE_LAT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_param_tx_if.slave     word_if,
  output logic                 e,
  output logic                 busy,
  output logic                 frame_start,
  output logic                 shift_done,
  output logic                 settled,
  output logic [3:0]           bit_idx
);

  localparam int CW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_SETTLED
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             accept;

  // a word is taken only when the block is idle or settled; nothing is buffered
  assign accept = word_if.word_valid && word_if.word_ready;

  // state, shift register and counters; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE, S_SETTLED: begin
        if (accept) begin
          state_d   = S_SHIFT;
          shreg_d   = word_if.word_in;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          shreg_d   = '0;
          if (PIPE_LAT == 0) begin
            state_d = S_SETTLED;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = CW'(PIPE_LAT);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          shreg_d   = shreg_q >> 1;
        end
      end
      S_WAIT: begin
        // counter holds the remaining wait cycles including the current one
        if (wait_cnt_q <= CW'(1)) begin
          state_d    = S_SETTLED;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs decoded from registered state; e comes from the shift register LSB
  always_comb begin
    e                  = 1'b0;
    busy               = 1'b0;
    frame_start        = 1'b0;
    shift_done         = 1'b0;
    settled            = 1'b0;
    bit_idx            = 4'd0;
    word_if.word_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        word_if.word_ready = 1'b1;
      end
      S_SHIFT: begin
        e           = shreg_q[0];
        busy        = 1'b1;
        bit_idx     = bit_cnt_q;
        frame_start = (bit_cnt_q == 4'd0);
        shift_done  = (bit_cnt_q == LAST_BIT);
      end
      S_WAIT: begin
        busy = 1'b1;
      end
      S_SETTLED: begin
        settled            = 1'b1;
        word_if.word_ready = 1'b1;
      end
      default: begin
        word_if.word_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_param_tx.sv
// tb/tb_serial_param_tx.sv - randomized and directed bench for serial_param_tx against a timeline model
module tb_serial_param_tx;

  localparam int ND = 3;
  localparam int WS [ND] = '{12, 12, 4};
  localparam int PS [ND] = '{6, 0, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]   word_drv [ND];
  logic [ND-1:0] valid_drv;

  wire [ND-1:0]      e_o, busy_o, fs_o, sd_o, st_o, rdy_o;
  wire [ND-1:0][3:0] bidx_o;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    serial_param_tx_if #(.WIDTH(WS[g])) bus ();
    assign bus.word_in    = word_drv[g][WS[g]-1:0];
    assign bus.word_valid = valid_drv[g];
    assign rdy_o[g]       = bus.word_ready;
    serial_param_tx #(.WIDTH(WS[g]), .PIPE_LAT(PS[g])) dut (
      .clk         (clk),
      .rst         (rst),
      .word_if     (bus),
      .e           (e_o[g]),
      .busy        (busy_o[g]),
      .frame_start (fs_o[g]),
      .shift_done  (sd_o[g]),
      .settled     (st_o[g]),
      .bit_idx     (bidx_o[g])
    );
  end

  // Timeline model: t counts edges since the accept edge (t=1 shows bit 0).
  int          m_have [ND];
  int          m_t    [ND];
  logic [15:0] m_word [ND];

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst) begin
        m_have[d] <= 0;
        m_t[d]    <= 0;
        m_word[d] <= '0;
      end else if (valid_drv[d] && (m_have[d] == 0 || m_t[d] > WS[d] + PS[d])) begin
        m_have[d] <= 1;
        m_t[d]    <= 1;
        m_word[d] <= word_drv[d];
      end else if (m_have[d] != 0 && m_t[d] <= WS[d] + PS[d]) begin
        m_t[d] <= m_t[d] + 1;
      end
    end
  end

  // {e, busy, frame_start, shift_done, settled, word_ready, bit_idx}
  function automatic logic [9:0] expv(input int d);
    logic       ee, bb, ff, ss, tt, rr;
    logic [3:0] bi;
    int         t, w, p;
    ee = 0; bb = 0; ff = 0; ss = 0; tt = 0; rr = 0; bi = 0;
    t = m_t[d]; w = WS[d]; p = PS[d];
    if (m_have[d] == 0) begin
      rr = 1;
    end else if (t <= w) begin
      ee = m_word[d][t-1];
      bb = 1;
      bi = 4'(t - 1);
      ff = (t == 1);
      ss = (t == w);
    end else if (t <= w + p) begin
      bb = 1;
    end else begin
      tt = 1;
      rr = 1;
    end
    return {ee, bb, ff, ss, tt, rr, bi};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      automatic logic [9:0] act = {e_o[d], busy_o[d], fs_o[d], sd_o[d], st_o[d], rdy_o[d], bidx_o[d]};
      automatic logic [9:0] exp = expv(d);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_cmp dut%0d at %0t got %b want %b", d, $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sends one word and acts as the receiving loader (bit k written in cycle k).
  task automatic send_collect(input int d, input logic [15:0] val, output logic [15:0] loaded,
                              output int settle_c, output int busy_cnt, output int sd_c);
    int n;
    n = 0;
    while (!rdy_o[d] && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", int'(rdy_o[d]), 1);
    word_drv[d]  = val;
    valid_drv[d] = 1'b1;
    tick();
    valid_drv[d] = 1'b0;
    loaded = '0; settle_c = -1; busy_cnt = 0; sd_c = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < WS[d]) begin
        loaded[c] = e_o[d];
        chk("bit_idx", int'(bidx_o[d]), c);
        chk("frame_start", int'(fs_o[d]), int'(c == 0));
      end
      if (busy_o[d]) busy_cnt++;
      if (sd_o[d] && sd_c < 0) sd_c = c;
      if (st_o[d] && settle_c < 0) settle_c = c;
    end
    chk("settled_hold", int'(st_o[d]), 1);
    tick();
  endtask

  initial begin
    logic [15:0] ld, col1, col2;
    int          sc, bc, sdc, fs2, pulses;
    for (int d = 0; d < ND; d++) word_drv[d] = '0;
    valid_drv = '0;
    repeat (3) tick();
    chk("rst_e", int'(e_o[0]), 0);
    chk("rst_ready", int'(rdy_o[0]), 1);
    chk("rst_settled", int'(st_o[0]), 0);
    rst = 1'b1;
    tick();

    // Test 1/2: 0xA5C, then loader values for 0xFFF and 0x001
    send_collect(0, 16'hA5C, ld, sc, bc, sdc);
    chk("t1_loaded", int'(ld), 'hA5C);
    chk("t1_settle_cycle", sc, 18);
    chk("t1_shift_done", sdc, 11);
    chk("t1_busy_cycles", bc, 18);
    send_collect(0, 16'hFFF, ld, sc, bc, sdc);
    chk("t2_loaded_fff", int'(ld), 'hFFF);
    send_collect(0, 16'h001, ld, sc, bc, sdc);
    chk("t2_loaded_001", int'(ld), 'h001);

    // Test 3: valid held high with 0x123 while 0x456 shifts
    word_drv[0]  = 16'h456;
    valid_drv[0] = 1'b1;
    tick();
    word_drv[0] = 16'h123;
    fs2 = -1; col1 = '0; col2 = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c < 12) col1[c] = e_o[0];
      if (fs_o[0] && c > 0 && fs2 < 0) begin
        fs2 = c;
        valid_drv[0] = 1'b0;
      end
      if (fs2 >= 0 && c - fs2 < 12) col2[c-fs2] = e_o[0];
    end
    tick();
    chk("t3_first_word", int'(col1), 'h456);
    chk("t3_second_start", fs2, 19);
    chk("t3_second_word", int'(col2), 'h123);

    // Test 4: async reset at shift cycle 5
    word_drv[0]  = 16'hFFF;
    valid_drv[0] = 1'b1;
    tick();
    valid_drv[0] = 1'b0;
    repeat (5) tick();
    #1;
    chk("t4_pre_bit_idx", int'(bidx_o[0]), 5);
    chk("t4_pre_busy", int'(busy_o[0]), 1);
    rst = 1'b0;
    #1;
    chk("t4_e", int'(e_o[0]), 0);
    chk("t4_busy", int'(busy_o[0]), 0);
    chk("t4_bit_idx", int'(bidx_o[0]), 0);
    chk("t4_ready", int'(rdy_o[0]), 1);
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sd_o[0] || st_o[0]) pulses++;
    end
    tick();
    chk("t4_no_pulses", pulses, 0);

    // Test 5: PIPE_LAT=0
    send_collect(1, 16'h800, ld, sc, bc, sdc);
    chk("t5_loaded", int'(ld), 'h800);
    chk("t5_shift_done", sdc, 11);
    chk("t5_settle_cycle", sc, 12);

    // Test 6: WIDTH=4, PIPE_LAT=2
    send_collect(2, 16'h9, ld, sc, bc, sdc);
    chk("t6_loaded", int'(ld), 9);
    chk("t6_busy_cycles", bc, 6);
    chk("t6_settle_cycle", sc, 6);

    // Random traffic with occasional async resets
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < ND; d++) begin
        valid_drv[d] = ($urandom_range(0, 3) == 0);
        word_drv[d]  = 16'($urandom);
      end
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 79) == 0) rst = 1'b0;
      tick();
    end
    rst = 1'b1;
    valid_drv = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
